// File: rtl/omem_write_sink_pkg.sv
// Shared OMEM write-stream definitions: row layout, lane bounds and beat encoding.
package omem_write_sink_pkg;

    localparam int unsigned DATA_ROW_WIDTH = 96;
    localparam int unsigned WORD_WIDTH     = 32;

    localparam int unsigned LANE_X_HI = 95;
    localparam int unsigned LANE_X_LO = 64;
    localparam int unsigned LANE_Y_HI = 63;
    localparam int unsigned LANE_Y_LO = 32;
    localparam int unsigned LANE_Z_HI = 31;
    localparam int unsigned LANE_Z_LO = 0;

    typedef enum logic [1:0] {
        BEAT_X = 2'd0,
        BEAT_Y = 2'd1,
        BEAT_Z = 2'd2
    } beat_t;

    function automatic logic [WORD_WIDTH-1:0] laneSel(
        input logic [DATA_ROW_WIDTH-1:0] row,
        input beat_t                     beat
    );
        logic [WORD_WIDTH-1:0] lane;
        case (beat)
            BEAT_Y:  lane = row[LANE_Y_HI:LANE_Y_LO];
            BEAT_Z:  lane = row[LANE_Z_HI:LANE_Z_LO];
            default: lane = row[LANE_X_HI:LANE_X_LO];
        endcase
        return lane;
    endfunction

endpackage

// File: rtl/omem_write_sink_if.sv
// OMEM write stream plus host read port; the producer/host side is master.
interface omem_write_sink_if
    import omem_write_sink_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 10
);
    logic [DATA_ROW_WIDTH-1:0] iOMEMWriteAddress;
    logic [DATA_ROW_WIDTH-1:0] iOMEMWriteData;
    logic                      iOMEMWriteEnable;
    logic                      iHostReadRequest;
    logic [ADDR_BITS-1:0]      iHostReadAddress;
    logic [WORD_WIDTH-1:0]     oHostReadData;
    logic                      oHostReadValid;

    modport master (
        output iOMEMWriteAddress, iOMEMWriteData, iOMEMWriteEnable,
        output iHostReadRequest, iHostReadAddress,
        input  oHostReadData, oHostReadValid
    );

    modport slave (
        input  iOMEMWriteAddress, iOMEMWriteData, iOMEMWriteEnable,
        input  iHostReadRequest, iHostReadAddress,
        output oHostReadData, oHostReadValid
    );

endinterface

// File: rtl/omem_write_sink_ram.sv
// 32-bit x 2^ADDR_BITS memory: synchronous write, registered read-first read.
module omem_ram_1w1r
    import omem_write_sink_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 10
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  writeEnable,
    input  logic [ADDR_BITS-1:0]  writeAddress,
    input  logic [WORD_WIDTH-1:0] writeData,
    input  logic                  readRequest,
    input  logic [ADDR_BITS-1:0]  readAddress,
    output logic [WORD_WIDTH-1:0] readData,
    output logic                  readValid
);

    logic [WORD_WIDTH-1:0] mem [2**ADDR_BITS];

    // Storage has no reset so committed words survive a reset pulse.
    always_ff @(posedge Clock) begin
        if (writeEnable) begin
            mem[writeAddress] <= writeData;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            readValid <= 1'b0;
            readData  <= '0;
        end else begin
            readValid <= readRequest;
            if (readRequest) begin
                readData <= mem[readAddress];
            end
        end
    end

endmodule

// File: rtl/omem_write_sink.sv
// OMEM write sink: splits 3-beat write bursts into per-lane memory writes and tracks status.
module omem_write_sink
    import omem_write_sink_pkg::*;
#(
    parameter int unsigned ADDR_BITS  = 10,
    parameter int unsigned COUNT_BITS = 16
) (
    input  logic                  Clock,
    input  logic                  Reset,
    omem_write_sink_if.slave      omemBus,
    output logic [COUNT_BITS-1:0] oWriteCount,
    output logic                  oBurstError,
    output logic                  oAddrError,
    output logic [1:0]            oBeat
);

    beat_t                 state;
    beat_t                 nextState;
    logic                  laneWrite;
    logic                  burstDrop;
    logic [WORD_WIDTH-1:0] laneAddr;
    logic [WORD_WIDTH-1:0] laneData;
    logic                  addrOk;
    logic                  writeCommit;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state <= BEAT_X;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        laneWrite = 1'b0;
        burstDrop = 1'b0;
        case (state)
            BEAT_X: begin
                if (omemBus.iOMEMWriteEnable) begin
                    laneWrite = 1'b1;
                    nextState = BEAT_Y;
                end
            end
            BEAT_Y: begin
                if (omemBus.iOMEMWriteEnable) begin
                    laneWrite = 1'b1;
                    nextState = BEAT_Z;
                end else begin
                    burstDrop = 1'b1;
                    nextState = BEAT_X;
                end
            end
            BEAT_Z: begin
                laneWrite = omemBus.iOMEMWriteEnable;
                burstDrop = !omemBus.iOMEMWriteEnable;
                nextState = BEAT_X;
            end
            default: nextState = BEAT_X;
        endcase
    end

    always_comb begin
        laneAddr    = laneSel(omemBus.iOMEMWriteAddress, state);
        laneData    = laneSel(omemBus.iOMEMWriteData, state);
        addrOk      = (laneAddr[WORD_WIDTH-1:ADDR_BITS] == '0);
        // Gated by Reset so a beat sampled during reset never lands in memory.
        writeCommit = laneWrite && addrOk && Reset;
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            oWriteCount <= '0;
            oBurstError <= 1'b0;
            oAddrError  <= 1'b0;
        end else begin
            if (writeCommit && (oWriteCount != '1)) begin
                oWriteCount <= oWriteCount + 1'b1;
            end
            if (burstDrop) begin
                oBurstError <= 1'b1;
            end
            if (laneWrite && !addrOk) begin
                oAddrError <= 1'b1;
            end
        end
    end

    assign oBeat = state;

    omem_ram_1w1r #(
        .ADDR_BITS(ADDR_BITS)
    ) uRam (
        .Clock       (Clock),
        .Reset       (Reset),
        .writeEnable (writeCommit),
        .writeAddress(laneAddr[ADDR_BITS-1:0]),
        .writeData   (laneData),
        .readRequest (omemBus.iHostReadRequest),
        .readAddress (omemBus.iHostReadAddress),
        .readData    (omemBus.oHostReadData),
        .readValid   (omemBus.oHostReadValid)
    );

endmodule

// File: doc/omem_write_sink.md
# omem_write_sink

Receiving end of the IO station's output-memory (OMEM) write stream. It captures each 3-cycle write-enable burst and stores the three 32-bit lanes of the 96-bit data row into an on-block output memory, one lane per beat. Each lane goes to the address carried in the matching lane of the address row. A host-side read port lets the testbench or external logic drain the results; sticky status flags report malformed bursts and out-of-range addresses.

## Interface
Parameters:
- ADDR_BITS, 10: word-address width; memory depth is 2^ADDR_BITS 32-bit words.
- COUNT_BITS, 16: width of the written-word counter.

Ports:
- Clock  in  1: single clock; all logic on posedge.
- Reset  in  1: synchronous, active-low.
- iOMEMWriteAddress  in  96: three 32-bit word addresses; lane X [95:64], lane Y [63:32], lane Z [31:0].
- iOMEMWriteData  in  96: three 32-bit data words, same lane layout.
- iOMEMWriteEnable  in  1: high for 3 consecutive cycles per burst; may stay high 6, 9, … cycles for back-to-back bursts.
- iHostReadRequest  in  1: read strobe.
- iHostReadAddress  in  ADDR_BITS: host word address.
- oHostReadData  out  32: read data.
- oHostReadValid  out  1: high exactly one cycle per accepted request.
- oWriteCount  out  COUNT_BITS: number of words committed to memory, saturating.
- oBurstError  out  1: sticky; set when enable drops mid-burst.
- oAddrError  out  1: sticky; set when a lane address is out of range.
- oBeat  out  2: current FSM state encoding (0, 1 or 2).

## Operation
- FSM states (oBeat encoding): BEAT_X=0, BEAT_Y=1, BEAT_Z=2.
- BEAT_X with enable high: write lane X, go to BEAT_Y. With enable low: stay.
- BEAT_Y with enable high: write lane Y, go to BEAT_Z. With enable low: set oBurstError, go to BEAT_X, no write.
- BEAT_Z with enable high: write lane Z, go to BEAT_X. With enable low: set oBurstError, go to BEAT_X.
- Back-to-back bursts wrap BEAT_Z to BEAT_X with no idle cycle.
- Lane write rule: mem[laneAddr[ADDR_BITS-1:0]] ← laneData, only if laneAddr[31:ADDR_BITS]==0.
  - Otherwise the write is dropped, oAddrError is set, and the beat still advances.
- oWriteCount increments by 1 per committed word. It saturates at all-ones and does not wrap.
- Host reads are read-first: a read and a write to the same address in the same cycle returns the old word.
- Memory contents are not cleared by reset.
- Sticky flags clear only on reset.

## Timing
- Reset (Reset==0 at posedge) sets state BEAT_X, oWriteCount=0, oBurstError=0, oAddrError=0, oHostReadValid=0, oHostReadData=0.
- Reset mid-burst abandons the burst. Writes already committed remain. The first enable after release is treated as lane X.
- Write: the memory updates at the posedge where enable is sampled. The word is host-readable from the next cycle.
- Host read latency: 1 cycle; oHostReadValid/oHostReadData are registered.
  - A request every cycle yields valid every cycle.
  - oHostReadData holds its last value while valid is low.
- A request sampled during reset is discarded.
- Address/data rows are sampled per beat. The block does not require them to stay stable across a burst.

## Structure
- Shared definitions header (existing): DATA_ROW_WIDTH (96), lane slice bounds for X/Y/Z, OMEM word width (32). New constants go there, not in this block.
- One sub-module, omem_ram_1w1r: 32 × 2^ADDR_BITS memory with synchronous write, registered read-first read, no reset on storage.
- FSM, lane mux, range check, counter and flags live in the top level.

## Test plan
- Single burst: addr {0x10,0x11,0x12}, data {0xAAAA0001,0xAAAA0002,0xAAAA0003}, enable 3 cycles → host reads 0x10/0x11/0x12 return those words; oWriteCount=3; flags 0; oBeat back to 0.
- Back-to-back: enable held 6 cycles, second row addr {0x20,0x21,0x22} → all 6 words stored; oWriteCount=6; oBurstError=0.
- Truncated burst: enable high 2 cycles then low → lanes X, Y written; oBurstError=1 next cycle; oWriteCount=2. Following 3-cycle burst starts at lane X.
- Out-of-range: ADDR_BITS=10, lane Y addr 0x400 → X and Z written, Y dropped; oAddrError=1; oWriteCount=2.
- Same-cycle collision: host reads 0x10 (old 0x5) while lane X writes 0x10=0x9 → returns 0x5; read next cycle returns 0x9.
- Reset mid-burst: Reset low at beat Y → oBeat=0, counters/flags 0. Word written at beat X is still readable.
